// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types for the HI/LO multiply/divide front end.
package mips_cpu_hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_START = 2'd1,
    ST_DIV_WAIT  = 2'd2
  } hilo_state_t;

  // 32-bit two's-complement negation; wraps so that neg32(0x80000000) == 0x80000000.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/mips_cpu_hilo_unit_if.sv
// Execute-stage and divider-facing signals of the HI/LO unit.
interface mips_cpu_hilo_unit_if;
  import mips_cpu_hilo_pkg::*;

  logic        op_valid;
  hilo_op_t    op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;

  modport slave (
    input  op_valid, op, rs_val, rt_val, div_quotient, div_remainder, div_done,
    output stall, hi, lo, dbz, div_start, div_dividend, div_divisor
  );

  modport master (
    output op_valid, op, rs_val, rt_val, div_quotient, div_remainder, div_done,
    input  stall, hi, lo, dbz, div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO register file with single-cycle multiply and sign-corrected divide sequencing.
//   state        | meaning
//   ST_IDLE      | accepting ops; MULT/MT*/MF* and zero-divisor DIVs finish here
//   ST_DIV_START | one-cycle div_start pulse with latched magnitudes
//   ST_DIV_WAIT  | waiting for div_done (bounded by DIV_TIMEOUT)
module mips_cpu_hilo_unit
  import mips_cpu_hilo_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_cpu_hilo_unit_if.slave  bus
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);

  hilo_state_t   state, state_nx;
  logic [31:0]   hi_q, lo_q, dvd_q, dvs_q;
  logic          dbz_q, neg_q, neg_r;
  logic [TW-1:0] tmo_cnt;
  logic          accept, is_div, div_zero, sgn, tmo_hit;
  logic          stall_c, start_c, div_wr;
  logic [63:0]   prod_s, prod_u;

  assign accept   = bus.op_valid && (state == ST_IDLE);
  assign is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign sgn      = (bus.op == OP_DIV);
  assign div_zero = (bus.rt_val == 32'd0);
  assign tmo_hit  = (tmo_cnt == '0);

  // Low 64 bits of the product of the sign-extended operands equal the signed product.
  assign prod_s = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
  assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (accept && is_div && !div_zero) state_nx = ST_DIV_START;
      ST_DIV_START: state_nx = ST_DIV_WAIT;
      ST_DIV_WAIT:  if (bus.div_done || tmo_hit) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_c = 1'b0;
    start_c = 1'b0;
    div_wr  = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_DIV_START: begin
        stall_c = bus.op_valid;
        start_c = 1'b1;
      end
      ST_DIV_WAIT: begin
        stall_c = bus.op_valid;
        div_wr  = bus.div_done;
      end
      default: stall_c = bus.op_valid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (accept) begin
        case (bus.op)
          OP_MULT:  {hi_q, lo_q} <= prod_s;
          OP_MULTU: {hi_q, lo_q} <= prod_u;
          OP_MTHI:  hi_q <= bus.rs_val;
          OP_MTLO:  lo_q <= bus.rs_val;
          OP_DIV, OP_DIVU: begin
            if (div_zero) begin
              dbz_q <= 1'b1;
            end else begin
              dbz_q <= 1'b0;
              dvd_q <= (sgn && bus.rs_val[31]) ? neg32(bus.rs_val) : bus.rs_val;
              dvs_q <= (sgn && bus.rt_val[31]) ? neg32(bus.rt_val) : bus.rt_val;
              neg_q <= sgn && (bus.rs_val[31] ^ bus.rt_val[31]);
              neg_r <= sgn && bus.rs_val[31];
            end
          end
          default: ;
        endcase
      end
      if (div_wr) begin
        lo_q <= neg_q ? neg32(bus.div_quotient)  : bus.div_quotient;
        hi_q <= neg_r ? neg32(bus.div_remainder) : bus.div_remainder;
      end
      if (state == ST_DIV_START)
        tmo_cnt <= TW'(DIV_TIMEOUT - 1);
      else if (state == ST_DIV_WAIT && !tmo_hit)
        tmo_cnt <= tmo_cnt - TW'(1);
    end
  end

  // The timeout is only a safety net; a healthy divider always answers first.
  div_timeout_never: assert property (@(posedge clk) disable iff (reset)
    !(state == ST_DIV_WAIT && tmo_hit && !bus.div_done));

  assign bus.stall        = stall_c;
  assign bus.div_start    = start_c;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.dbz          = dbz_q;
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Bench for mips_cpu_hilo_unit: divider stub plus an arithmetic reference model of HI/LO.
module tb_mips_cpu_hilo_unit;
  import mips_cpu_hilo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_hilo_unit_if hif();

  mips_cpu_hilo_unit #(.DIV_TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  // Divider stub: 32 cycles after sampling start, done stays high until the next start.
  logic        dv_done;
  logic [31:0] dv_q, dv_r, dv_a, dv_b;
  int          dv_cnt;

  always @(posedge clk) begin
    if (reset) begin
      dv_done <= 1'b0;
      dv_q    <= '0;
      dv_r    <= '0;
      dv_a    <= '0;
      dv_b    <= '0;
      dv_cnt  <= 0;
    end else if (hif.div_start) begin
      if (hif.div_dividend == 32'd0) begin
        dv_done <= 1'b1;
        dv_q    <= '0;
        dv_r    <= '0;
        dv_cnt  <= 0;
      end else begin
        dv_done <= 1'b0;
        dv_a    <= hif.div_dividend;
        dv_b    <= hif.div_divisor;
        dv_cnt  <= 32;
      end
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) begin
        dv_done <= 1'b1;
        dv_q    <= (dv_b == 32'd0) ? 32'hFFFF_FFFF : dv_a / dv_b;
        dv_r    <= (dv_b == 32'd0) ? dv_a : dv_a % dv_b;
      end
    end
  end

  assign hif.div_done      = dv_done;
  assign hif.div_quotient  = dv_q;
  assign hif.div_remainder = dv_r;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_mag_a, m_mag_b;
  logic        m_dbz, m_start;
  int          m_busy;
  bit          accepted;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies one clock edge to the model using the values the bench is driving.
  task automatic model_edge();
    longint a, b, q, r, p;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_busy = 0; m_start = 1'b0;
    end else if (m_busy > 0) begin
      m_start = 1'b0;
      m_busy--;
      if (m_busy == 0) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (hif.op_valid) begin
      accepted = 1'b1;
      case (hif.op)
        OP_MULT: begin
          p = longint'($signed(hif.rs_val)) * longint'($signed(hif.rt_val));
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        OP_MULTU: begin
          p = longint'({32'd0, hif.rs_val}) * longint'({32'd0, hif.rt_val});
          m_hi = p[63:32]; m_lo = p[31:0];
        end
        OP_MTHI: m_hi = hif.rs_val;
        OP_MTLO: m_lo = hif.rs_val;
        OP_DIV, OP_DIVU: begin
          if (hif.rt_val == 32'd0) begin
            m_dbz = 1'b1;
          end else begin
            m_dbz = 1'b0;
            if (hif.op == OP_DIV) begin
              a = longint'($signed(hif.rs_val));
              b = longint'($signed(hif.rt_val));
            end else begin
              a = longint'({32'd0, hif.rs_val});
              b = longint'({32'd0, hif.rt_val});
            end
            q = a / b;
            r = a % b;
            m_pend_lo = q[31:0];
            m_pend_hi = r[31:0];
            p = (a < 0) ? -a : a;
            m_mag_a = p[31:0];
            p = (b < 0) ? -b : b;
            m_mag_b = p[31:0];
            m_busy  = (hif.rs_val == 32'd0) ? 2 : 34;
            m_start = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("stall", hif.stall, (hif.op_valid && m_busy > 0));
    chk("hi", hif.hi, m_hi);
    chk("lo", hif.lo, m_lo);
    chk("dbz", hif.dbz, m_dbz);
    chk("div_start", hif.div_start, m_start);
    if (m_start) begin
      chk("div_dividend", hif.div_dividend, m_mag_a);
      chk("div_divisor", hif.div_divisor, m_mag_b);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b);
    hif.op_valid = 1'b1;
    hif.op       = o;
    hif.rs_val   = a;
    hif.rt_val   = b;
    accepted     = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) cycle();
    if (!accepted) chk("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic idle(input int n);
    hif.op_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      hif.op     = hilo_op_t'($urandom_range(0, 7));
      hif.rs_val = $urandom;
      hif.rt_val = $urandom;
      cycle();
    end
  endtask

  function automatic logic [31:0] pick(input int zero_bias);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < zero_bias) return 32'd0;
    case (sel)
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'(32'($urandom_range(1, 50)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    hif.op_valid = 1'b0;
    hif.op       = OP_MFHI;
    hif.rs_val   = '0;
    hif.rt_val   = '0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    reset = 1'b0;
    idle(2);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", hif.hi, 32'hFFFF_FFFF);
    chk("mult_lo", hif.lo, 32'hFFFF_FFFA);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi", hif.hi, 32'h0000_0002);
    chk("multu_lo", hif.lo, 32'hFFFF_FFFA);
    idle(1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(OP_MFLO, 32'd0, 32'd0);
    chk("div_neg_lo", hif.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hif.hi, 32'hFFFF_FFFF);
    idle(1);

    issue(OP_DIVU, 32'd100, 32'd0);
    chk("dbz_set", hif.dbz, 32'd1);
    idle(1);
    issue(OP_DIVU, 32'd100, 32'd7);
    idle(36);
    chk("divu_lo", hif.lo, 32'd14);
    chk("divu_hi", hif.hi, 32'd2);
    chk("dbz_clr", hif.dbz, 32'd0);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(36);
    chk("ovf_lo", hif.lo, 32'h8000_0000);
    chk("ovf_hi", hif.hi, 32'd0);
    issue(OP_MTLO, 32'h5555_AAAA, 32'd0);
    issue(OP_DIV, 32'd0, 32'd5);
    idle(2);
    chk("zero_dvd_lo", hif.lo, 32'd0);
    chk("zero_dvd_hi", hif.hi, 32'd0);

    issue(OP_DIVU, 32'd10, 32'd3);
    issue(OP_DIVU, 32'd20, 32'd6);
    chk("b2b_first_lo", hif.lo, 32'd3);
    chk("b2b_first_hi", hif.hi, 32'd1);
    idle(36);
    chk("b2b_second_lo", hif.lo, 32'd3);
    chk("b2b_second_hi", hif.hi, 32'd2);

    // Reset in the middle of a divide, with HI/LO holding nonzero values.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    issue(OP_DIV, 32'h0001_0000, 32'd9);
    idle(11);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    hif.op_valid = 1'b1;
    hif.op       = OP_MFLO;
    cycle();
    chk("post_reset_hi", hif.hi, 32'd0);
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_after_reset", hif.hi, 32'h0000_1234);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      issue(hilo_op_t'($urandom_range(0, 7)), pick(1), pick(2));
      idle($urandom_range(0, 2));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
